delaychain_sequencer: RTL and testbench



---
 rtl/delaychain_sequencer_pkg.sv | 26 ++
 rtl/delaychain_sequencer_if.sv | 26 ++
 rtl/delaychain_sequencer_sat_counter.sv | 24 ++
 rtl/delaychain_sequencer.sv | 123 ++++++++++++
 tb/tb_delaychain_sequencer.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/delaychain_sequencer_pkg.sv
// Shared definitions for the delay-chain measurement sequencer.
//   state_t          : sequencer FSM states
//   LAT_DEFAULT      : default register stages from chain_din to chain_dout
//   TRIAL_CYCLES     : cycles per trial at the default latency (LAT+2)
//   trial_cycles()   : per-trial cycle count for an arbitrary latency
package delaychain_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FLUSH,
    ST_LAUNCH,
    ST_WAIT,
    ST_CHECK,
    ST_DONE
  } state_t;

  localparam int unsigned LAT_DEFAULT = 2;

  // One trial is LAUNCH + LAT WAIT cycles + CHECK.
  function automatic int unsigned trial_cycles(input int unsigned lat);
    return lat + 2;
  endfunction

  localparam int unsigned TRIAL_CYCLES = trial_cycles(LAT_DEFAULT);

endpackage

// File: rtl/delaychain_sequencer_if.sv
// Control-side interface of the delay-chain sequencer.
//   start, mode, num_trials        : run request and its settings (master -> slave)
//   busy, done, trial_count,
//   fail_count                     : run status and results (slave -> master)
interface delaychain_sequencer_if #(
  parameter int unsigned TRIALS_W = 8,
  parameter int unsigned CNT_W    = 8
);
  logic                start;
  logic                mode;
  logic [TRIALS_W-1:0] num_trials;
  logic                busy;
  logic                done;
  logic [TRIALS_W-1:0] trial_count;
  logic [CNT_W-1:0]    fail_count;

  modport master (
    output start, mode, num_trials,
    input  busy, done, trial_count, fail_count
  );

  modport slave (
    input  start, mode, num_trials,
    output busy, done, trial_count, fail_count
  );
endinterface

// File: rtl/delaychain_sequencer_sat_counter.sv
// Saturating up-counter.
//   clk, rst : clock, synchronous active-high reset
//   clr      : synchronous clear
//   en       : count enable; holds at all-ones once reached
//   count    : registered count value
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/delaychain_sequencer.sv
// Measurement sequencer for the inverter delay-chain test structure.
// A start pulse flushes the chain with 0, then runs num_trials trials that
// each toggle chain_din and check chain_dout exactly LAT+1 edges later.
//   clk, rst    : clock (shared with the chain), synchronous active-high reset
//   ctrl        : control interface (start/mode/num_trials in; busy/done/counts out)
//   chain_din   : registered data into the chain
//   chain_test  : registered test select into the chain (latched mode)
//   chain_dout  : chain output register, sampled only in CHECK
module delaychain_sequencer
  import delaychain_pkg::*;
#(
  parameter int unsigned LAT      = LAT_DEFAULT,
  parameter int unsigned TRIALS_W = 8,
  parameter int unsigned CNT_W    = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  delaychain_sequencer_if.slave  ctrl,
  output logic                   chain_din,
  output logic                   chain_test,
  input  logic                   chain_dout
);

  localparam int unsigned TMR_W = $clog2(LAT + 2);

  state_t              state;
  logic [TMR_W-1:0]    timer;
  logic [TRIALS_W-1:0] num_lat;
  logic [TRIALS_W-1:0] trial_count;
  logic [TRIALS_W-1:0] trial_next;
  logic [CNT_W-1:0]    fail_count;
  logic                busy;
  logic                done;
  logic                accept;
  logic                fail;

  always_comb begin
    accept     = (state == ST_IDLE) && ctrl.start;
    fail       = (state == ST_CHECK) && (chain_dout != chain_din);
    trial_next = trial_count + TRIALS_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      timer       <= '0;
      num_lat     <= '0;
      trial_count <= '0;
      chain_din   <= 1'b0;
      chain_test  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (ctrl.start) begin
            chain_test  <= ctrl.mode;
            num_lat     <= ctrl.num_trials;
            trial_count <= '0;
            chain_din   <= 1'b0;
            timer       <= TMR_W'(LAT);
            busy        <= 1'b1;
            state       <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if (timer == '0) begin
            if (num_lat == '0) begin
              done  <= 1'b1;
              state <= ST_DONE;
            end else begin
              state <= ST_LAUNCH;
            end
          end else begin
            timer <= timer - TMR_W'(1);
          end
        end
        ST_LAUNCH: begin
          // The edge leaving LAUNCH is the launch edge; CHECK samples LAT+1 edges later.
          chain_din <= ~chain_din;
          timer     <= TMR_W'(LAT - 1);
          state     <= ST_WAIT;
        end
        ST_WAIT: begin
          if (timer == '0) begin
            state <= ST_CHECK;
          end else begin
            timer <= timer - TMR_W'(1);
          end
        end
        ST_CHECK: begin
          trial_count <= trial_next;
          if (trial_next == num_lat) begin
            done  <= 1'b1;
            state <= ST_DONE;
          end else begin
            state <= ST_LAUNCH;
          end
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_fail_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (accept),
    .en    (fail),
    .count (fail_count)
  );

  assign ctrl.busy        = busy;
  assign ctrl.done        = done;
  assign ctrl.trial_count = trial_count;
  assign ctrl.fail_count  = fail_count;

endmodule

// File: tb/tb_delaychain_sequencer.sv
module tb_delaychain_sequencer;
  import delaychain_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // DUT0: default widths, selectable chain model
  delaychain_sequencer_if #(.TRIALS_W(8), .CNT_W(8)) c0 ();
  logic din0, test0, dout0;
  logic r1, r2, r3;
  int   sel;  // 0: 2-reg chain, 1: stuck at 0, 2: 3-reg chain

  always @(posedge clk) begin
    r1 <= din0;
    r2 <= r1;
    r3 <= r2;
  end

  always_comb begin
    case (sel)
      1:       dout0 = 1'b0;
      2:       dout0 = r3;
      default: dout0 = r2;
    endcase
  end

  delaychain_sequencer #(.LAT(2), .TRIALS_W(8), .CNT_W(8)) dut0 (
    .clk        (clk),
    .rst        (rst),
    .ctrl       (c0),
    .chain_din  (din0),
    .chain_test (test0),
    .chain_dout (dout0)
  );

  // DUT1: 2-bit fail counter, chain always returns the wrong value
  delaychain_sequencer_if #(.TRIALS_W(8), .CNT_W(2)) c1 ();
  logic din1, test1, dout1;
  assign dout1 = ~din1;

  delaychain_sequencer #(.LAT(2), .TRIALS_W(8), .CNT_W(2)) dut1 (
    .clk        (clk),
    .rst        (rst),
    .ctrl       (c1),
    .chain_din  (din1),
    .chain_test (test1),
    .chain_dout (dout1)
  );

  // Pulse start on DUT0; returns #1 after the accept edge (cycle 1).
  task automatic launch0(input logic m, input logic [7:0] n);
    c0.mode       = m;
    c0.num_trials = n;
    c0.start      = 1'b1;
    @(posedge clk); #1;
    c0.start = 1'b0;
  endtask

  // Cycle index (accept edge = cycle 1 boundary) at which done is seen; 200 on timeout.
  task automatic wait_done0(output int cyc);
    cyc = 1;
    while (c0.done !== 1'b1 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    c0.start = 1'b0; c0.mode = 1'b0; c0.num_trials = '0;
    c1.start = 1'b0; c1.mode = 1'b0; c1.num_trials = '0;
    sel = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if ({din0, test0, c0.busy, c0.done} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl: got din/test/busy/done=%b%b%b%b want 0000", din0, test0, c0.busy, c0.done);
    end
    checks++;
    if (c0.trial_count !== 8'd0 || c0.fail_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_counts: got tc=%0d fc=%0d want 0 0", c0.trial_count, c0.fail_count);
    end
  endtask

  task automatic test_healthy;
    int cyc;
    sel = 0;
    launch0(1'b1, 8'd5);
    // Changes after acceptance must not affect the run.
    c0.mode = 1'b0; c0.num_trials = 8'd1;
    checks++;
    if (c0.busy !== 1'b1) begin
      errors++;
      $display("FAIL healthy_busy: got %b want 1", c0.busy);
    end
    wait_done0(cyc);
    checks++;
    if (cyc !== 24) begin
      errors++;
      $display("FAIL healthy_done_cycle: got %0d want 24", cyc);
    end
    checks++;
    if (c0.trial_count !== 8'd5 || c0.fail_count !== 8'd0) begin
      errors++;
      $display("FAIL healthy_counts: got tc=%0d fc=%0d want 5 0", c0.trial_count, c0.fail_count);
    end
    checks++;
    if (test0 !== 1'b1 || din0 !== 1'b1) begin
      errors++;
      $display("FAIL healthy_chain_regs: got test=%b din=%b want 1 1", test0, din0);
    end
    @(posedge clk); #1;
    checks++;
    if (c0.done !== 1'b0 || c0.busy !== 1'b0 || c0.trial_count !== 8'd5 || test0 !== 1'b1) begin
      errors++;
      $display("FAIL healthy_after_done: got done=%b busy=%b tc=%0d test=%b want 0 0 5 1",
               c0.done, c0.busy, c0.trial_count, test0);
    end
  endtask

  task automatic test_stuck0;
    int cyc;
    sel = 1;
    launch0(1'b0, 8'd5);
    wait_done0(cyc);
    checks++;
    if (cyc !== 24 || c0.fail_count !== 8'd3 || c0.trial_count !== 8'd5 || test0 !== 1'b0) begin
      errors++;
      $display("FAIL stuck0: got cyc=%0d fc=%0d tc=%0d test=%b want 24 3 5 0",
               cyc, c0.fail_count, c0.trial_count, test0);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_slow;
    int cyc;
    sel = 2;
    launch0(1'b1, 8'd4);
    wait_done0(cyc);
    checks++;
    if (cyc !== 20 || c0.fail_count !== 8'd4 || c0.trial_count !== 8'd4) begin
      errors++;
      $display("FAIL slow_chain: got cyc=%0d fc=%0d tc=%0d want 20 4 4",
               cyc, c0.fail_count, c0.trial_count);
    end
    @(posedge clk); #1;
    sel = 0;
  endtask

  task automatic test_saturation;
    int cyc;
    c1.mode = 1'b1; c1.num_trials = 8'd7; c1.start = 1'b1;
    @(posedge clk); #1;
    c1.start = 1'b0;
    cyc = 1;
    while (c1.done !== 1'b1 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (cyc !== 3 + 7 * TRIAL_CYCLES + 1) begin
      errors++;
      $display("FAIL sat_done_cycle: got %0d want 32", cyc);
    end
    checks++;
    if (c1.fail_count !== 2'd3 || c1.trial_count !== 8'd7) begin
      errors++;
      $display("FAIL saturation: got fc=%0d tc=%0d want 3 7", c1.fail_count, c1.trial_count);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_zero_trials;
    int cyc;
    launch0(1'b0, 8'd0);
    // Start held high while busy, including the DONE cycle: must be ignored.
    c0.num_trials = 8'd3;
    c0.start      = 1'b1;
    wait_done0(cyc);
    checks++;
    if (cyc !== 4 || c0.trial_count !== 8'd0 || c0.fail_count !== 8'd0) begin
      errors++;
      $display("FAIL zero_trials: got cyc=%0d tc=%0d fc=%0d want 4 0 0",
               cyc, c0.trial_count, c0.fail_count);
    end
    @(posedge clk); #1;
    c0.start = 1'b0;
    checks++;
    if (c0.busy !== 1'b0 || c0.done !== 1'b0) begin
      errors++;
      $display("FAIL start_in_done_ignored: got busy=%b done=%b want 0 0", c0.busy, c0.done);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (c0.busy !== 1'b0 || c0.trial_count !== 8'd0) begin
      errors++;
      $display("FAIL idle_after_zero: got busy=%b tc=%0d want 0 0", c0.busy, c0.trial_count);
    end
  endtask

  task automatic test_reset_mid_run;
    int cyc;
    bit seen_done;
    sel = 1;
    launch0(1'b1, 8'd5);
    // Cycle 13 is the first cycle of the third WAIT.
    repeat (12) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if ({din0, test0, c0.busy, c0.done} !== 4'b0000 ||
        c0.trial_count !== 8'd0 || c0.fail_count !== 8'd0) begin
      errors++;
      $display("FAIL mid_reset: got din=%b test=%b busy=%b done=%b tc=%0d fc=%0d want all 0",
               din0, test0, c0.busy, c0.done, c0.trial_count, c0.fail_count);
    end
    seen_done = 1'b0;
    repeat (30) begin
      @(posedge clk); #1;
      if (c0.done === 1'b1 || c0.busy === 1'b1) seen_done = 1'b1;
    end
    checks++;
    if (seen_done) begin
      errors++;
      $display("FAIL mid_reset_no_done: got activity=1 want 0");
    end
    sel = 0;
    launch0(1'b1, 8'd5);
    wait_done0(cyc);
    checks++;
    if (cyc !== 24 || c0.trial_count !== 8'd5 || c0.fail_count !== 8'd0) begin
      errors++;
      $display("FAIL run_after_reset: got cyc=%0d tc=%0d fc=%0d want 24 5 0",
               cyc, c0.trial_count, c0.fail_count);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_healthy();
    test_stuck0();
    test_slow();
    test_saturation();
    test_zero_trials();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
